// File: rtl/btn_event_pkg.sv
// Shared types and default timing for the button event FSM.
package btn_event_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_HELD} btn_state_t;

   // Defaults give a 1 ms tick at 38 MHz, 500 ms long-press, 100 ms repeat
   localparam int DEF_TICK_DIV     = 38000;
   localparam int DEF_LONG_TICKS   = 500;
   localparam int DEF_REPEAT_TICKS = 100;

endpackage

// File: rtl/btn_tick_prescaler.sv
// Tick prescaler: divides clk by TICK_DIV while enabled, held at 0 by clr.
// tick is high in the cycle the divider sits at its last count while enabled.
module btn_tick_prescaler
   import btn_event_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int TICK_W   = 16
) (
   input  logic clk,
   input  logic n_reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam logic [TICK_W-1:0] DIV_LAST = TICK_W'(TICK_DIV - 1);

   logic [TICK_W-1:0] div_q;

   assign tick = en & (div_q == DIV_LAST);

   // Divider count: cleared on clr, wraps to 0 on each tick
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         div_q <= '0;
      end else if (clr) begin
         div_q <= '0;
      end else if (en) begin
         div_q <= tick ? '0 : div_q + 1'b1;
      end
   end

endmodule

// File: rtl/button_event_fsm.sv
// Button event FSM: turns the debounced button level into single-cycle
// press / release / long-press / auto-repeat pulses plus a held level.
// Build option: define BTN_AUTO_REPEAT_EN to enable repeat_pulse while held;
// otherwise repeat_pulse is tied to 0 and HELD just waits for release.
module button_event_fsm
   import btn_event_pkg::*;
#(
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int TICK_W       = 16,
   parameter int LONG_TICKS   = DEF_LONG_TICKS,
   parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
   parameter int CNT_W        = 10
) (
   input  logic clk,
   input  logic n_reset,
   input  logic db_in,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic held
);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);

   if (TICK_DIV < 2 || LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_param
      $error("button_event_fsm: TICK_DIV must be >= 2, LONG_TICKS and REPEAT_TICKS >= 1");
   end

   btn_state_t        state;
   logic              db_q;
   logic              rise;
   logic              fall;
   logic              tick;
   logic              presc_clr;
   logic              presc_en;
   logic [CNT_W-1:0]  cnt_q;

   // Previous sample of the button level for edge detection
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         db_q <= 1'b0;
      end else begin
         db_q <= db_in;
      end
   end

   assign rise = db_in & ~db_q;
   assign fall = ~db_in & db_q;

   // Prescaler sits at 0 in IDLE and restarts on release
   assign presc_clr = (state == ST_IDLE) | fall;

`ifdef BTN_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_TICKS - 1);
   logic repeat_q;

   assign presc_en     = (state != ST_IDLE);
   assign repeat_pulse = repeat_q;
`else
   assign presc_en     = (state == ST_PRESSED);
   assign repeat_pulse = 1'b0;
`endif

   btn_tick_prescaler #(
      .TICK_DIV (TICK_DIV),
      .TICK_W   (TICK_W)
   ) u_prescaler (
      .clk     (clk),
      .n_reset (n_reset),
      .clr     (presc_clr),
      .en      (presc_en),
      .tick    (tick)
   );

   // Event FSM with duration counter; release always wins over a tick threshold
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state         <= ST_IDLE;
         cnt_q         <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         held          <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
         repeat_q      <= 1'b0;
`endif
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
         repeat_q      <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               cnt_q <= '0;
               if (rise) begin
                  state       <= ST_PRESSED;
                  press_pulse <= 1'b1;
                  held        <= 1'b1;
               end
            end
            ST_PRESSED: begin
               if (fall) begin
                  state         <= ST_IDLE;
                  release_pulse <= 1'b1;
                  held          <= 1'b0;
                  cnt_q         <= '0;
               end else if (tick) begin
                  if (cnt_q == LONG_LAST) begin
                     state      <= ST_HELD;
                     long_pulse <= 1'b1;
                     cnt_q      <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            ST_HELD: begin
               if (fall) begin
                  state         <= ST_IDLE;
                  release_pulse <= 1'b1;
                  held          <= 1'b0;
                  cnt_q         <= '0;
               end
`ifdef BTN_AUTO_REPEAT_EN
               else if (tick) begin
                  if (cnt_q == REP_LAST) begin
                     repeat_q <= 1'b1;
                     cnt_q    <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
`endif
            end
            default: begin
               state <= ST_IDLE;
               held  <= 1'b0;
               cnt_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_event_fsm.sv
// Bench for button_event_fsm with TICK_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2.
// Expected outputs come from an elapsed-time model of the button behaviour.
module tb_button_event_fsm;

   localparam int TICK_DIV     = 4;
   localparam int LONG_TICKS   = 3;
   localparam int REPEAT_TICKS = 2;
   localparam int LONG_CLK     = TICK_DIV * LONG_TICKS;
   localparam int REP_CLK      = TICK_DIV * REPEAT_TICKS;

   logic clk;
   logic n_reset;
   logic db_in;
   logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;

   int checks = 0;
   int errors = 0;

   // {press, release, long, repeat, held}
   logic [4:0] exp_q[$];

   button_event_fsm #(
      .TICK_DIV     (TICK_DIV),
      .TICK_W       (16),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS),
      .CNT_W        (10)
   ) dut (
      .clk           (clk),
      .n_reset       (n_reset),
      .db_in         (db_in),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse),
      .repeat_pulse  (repeat_pulse),
      .held          (held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] outs();
      return {press_pulse, release_pulse, long_pulse, repeat_pulse, held};
   endfunction

   // Reference model: tracks whether the button is down and for how many clocks
   bit m_pressed = 0;
   bit m_dbq = 0;
   int m_cyc = 0;
   int m_t0 = 0;

   always @(posedge clk) begin
      logic [4:0] e;
      int el;
      e = 5'b0;
      if (!n_reset) begin
         m_pressed = 0;
         m_dbq = 0;
         m_cyc = 0;
         exp_q.delete();
      end else begin
         if (!m_pressed && db_in && !m_dbq) begin
            e[4] = 1'b1;
            m_pressed = 1;
            m_t0 = m_cyc;
         end else if (m_pressed && !db_in && m_dbq) begin
            e[3] = 1'b1;
            m_pressed = 0;
         end else if (m_pressed) begin
            el = m_cyc - m_t0;
            if (el == LONG_CLK) e[2] = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
            if (el > LONG_CLK && ((el - LONG_CLK) % REP_CLK) == 0) e[1] = 1'b1;
`endif
         end
         e[0] = m_pressed;
         exp_q.push_back(e);
         m_dbq = db_in;
         m_cyc++;
      end
   end

   // Monitor: compare every cycle's registered outputs against the model
   always @(negedge clk) begin
      logic [4:0] e;
      if (!n_reset || exp_q.size() == 0) begin
         exp_q.delete();
         e = 5'b0;
      end else begin
         e = exp_q.pop_front();
      end
      checks++;
      if (outs() !== e) begin
         errors++;
         $display("FAIL outputs t=%0t got p/r/l/rp/h=%b expected %b", $time, outs(), e);
      end
   end

   task automatic drive(input logic v, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1 db_in = v;
      end
   endtask

   // Asynchronous reset pulse asserted mid-cycle, with an immediate output check
   task automatic mid_reset(input int cycles);
      @(posedge clk);
      #2 n_reset = 1'b0;
      #1;
      checks++;
      if (outs() !== 5'b0) begin
         errors++;
         $display("FAIL async_reset got %b expected 00000", outs());
      end
      for (int i = 0; i < cycles; i++) @(posedge clk);
      #2 n_reset = 1'b1;
   endtask

   initial begin
      logic v;
      n_reset = 1'b0;
      db_in   = 1'b0;
      #23;
      checks++;
      if (outs() !== 5'b0) begin
         errors++;
         $display("FAIL reset_state got %b expected 00000", outs());
      end
      @(posedge clk);
      #2 n_reset = 1'b1;
      drive(1'b0, 3);

      // short press
      drive(1'b1, 6);
      drive(1'b0, 5);

      // long hold
      drive(1'b1, 30);
      drive(1'b0, 5);

      // release exactly on the long threshold
      drive(1'b1, LONG_CLK);
      drive(1'b0, 5);

      // reset while HELD with button still down, then keep holding
      drive(1'b1, 20);
      mid_reset(2);
      drive(1'b1, 20);
      drive(1'b0, 4);

      // mid-cycle reset from idle
      mid_reset(1);
      drive(1'b0, 3);

      // back-to-back press
      drive(1'b1, 1);
      drive(1'b0, 1);
      drive(1'b1, 1);
      drive(1'b0, 5);

      // random runs
      v = 1'b0;
      for (int r = 0; r < 40; r++) begin
         v = ~v;
         drive(v, $urandom_range(1, 26));
         if (r == 25) mid_reset($urandom_range(1, 3));
      end
      drive(1'b0, 6);

      @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
